// File: rtl/fixed_point_addsub_cmp_signed.sv
// Signed Q(INTEGER_WIDTH).(DECIMAL_WIDTH) add/subtract with overflow flag plus signed three-way compare.
// LATENCY selects combinational outputs (0) or one enabled output register stage (1).
module fixed_point_addsub_cmp_signed #(
  parameter int INTEGER_WIDTH = 2,
  parameter int DECIMAL_WIDTH = 20,
  parameter int DATA_WIDTH    = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int LATENCY       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic                  add_sub,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  aeb,
  output logic                  agb,
  output logic                  alb
);

  logic [DATA_WIDTH-1:0]        b_eff;
  logic [DATA_WIDTH-1:0]        result_d;
  logic                         overflow_d;
  logic                         aeb_d;
  logic                         agb_d;
  logic                         alb_d;
  logic signed [DATA_WIDTH-1:0] a_sgn;
  logic signed [DATA_WIDTH-1:0] b_sgn;

  // Subtraction is A + ~B + 1, so the most-negative B wraps naturally.
  assign b_eff    = add_sub ? datab : ~datab;
  assign result_d = dataa + b_eff + {{(DATA_WIDTH-1){1'b0}}, ~add_sub};

  // Overflow when the effective addends agree in sign but the result does not.
  assign overflow_d = (dataa[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                      (result_d[DATA_WIDTH-1] != dataa[DATA_WIDTH-1]);

  assign a_sgn = dataa;
  assign b_sgn = datab;
  assign aeb_d = (dataa == datab);
  assign agb_d = (a_sgn > b_sgn);
  assign alb_d = ~aeb_d & ~agb_d;

  generate
    if (LATENCY == 0) begin : g_comb
      logic unused_clk_ok;
      assign unused_clk_ok = &{1'b0, clk, rst_n, clk_en};

      assign result   = result_d;
      assign overflow = overflow_d;
      assign aeb      = aeb_d;
      assign agb      = agb_d;
      assign alb      = alb_d;
    end else if (LATENCY == 1) begin : g_reg
      logic [DATA_WIDTH-1:0] result_q;
      logic                  overflow_q;
      logic                  aeb_q;
      logic                  agb_q;
      logic                  alb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_q   <= '0;
          overflow_q <= 1'b0;
          aeb_q      <= 1'b0;
          agb_q      <= 1'b0;
          alb_q      <= 1'b0;
        end else if (clk_en) begin
          result_q   <= result_d;
          overflow_q <= overflow_d;
          aeb_q      <= aeb_d;
          agb_q      <= agb_d;
          alb_q      <= alb_d;
        end
      end

      assign result   = result_q;
      assign overflow = overflow_q;
      assign aeb      = aeb_q;
      assign agb      = agb_q;
      assign alb      = alb_q;
    end else begin : g_bad_latency
      $error("fixed_point_addsub_cmp_signed: LATENCY must be 0 or 1");
    end
  endgenerate

endmodule

// File: tb/tb_fixed_point_addsub_cmp_signed.sv
// Directed bench: combinational instance (LATENCY=0) and registered instance (LATENCY=1) on shared inputs.
module tb_fixed_point_addsub_cmp_signed;

  localparam int DW = 22;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic [DW-1:0] dataa;
  logic [DW-1:0] datab;
  logic          add_sub;

  logic [DW-1:0] r0, r1;
  logic          ov0, ov1;
  logic          aeb0, agb0, alb0;
  logic          aeb1, agb1, alb1;

  int n_cmp  = 0;
  int n_fail = 0;

  fixed_point_addsub_cmp_signed #(.LATENCY(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .dataa(dataa), .datab(datab), .add_sub(add_sub),
    .result(r0), .overflow(ov0), .aeb(aeb0), .agb(agb0), .alb(alb0)
  );

  fixed_point_addsub_cmp_signed #(.LATENCY(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .dataa(dataa), .datab(datab), .add_sub(add_sub),
    .result(r1), .overflow(ov1), .aeb(aeb1), .agb(agb1), .alb(alb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks result, overflow and {aeb,agb,alb} of the combinational instance.
  task automatic comb_vec(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic op, input logic [DW-1:0] exp_r, input logic exp_ov,
                          input logic [2:0] exp_flags);
    dataa   = a;
    datab   = b;
    add_sub = op;
    #1;
    check({tag, ".result"},   32'(r0), 32'(exp_r));
    check({tag, ".overflow"}, 32'(ov0), 32'(exp_ov));
    check({tag, ".flags"},    32'({aeb0, agb0, alb0}), 32'(exp_flags));
  endtask

  task automatic reg_chk(input string tag, input logic [DW-1:0] exp_r, input logic exp_ov,
                         input logic [2:0] exp_flags);
    check({tag, ".result"},   32'(r1), 32'(exp_r));
    check({tag, ".overflow"}, 32'(ov1), 32'(exp_ov));
    check({tag, ".flags"},    32'({aeb1, agb1, alb1}), 32'(exp_flags));
  endtask

  initial begin
    rst_n   = 1'b0;
    clk_en  = 1'b0;
    dataa   = '0;
    datab   = '0;
    add_sub = 1'b1;
    #2;
    reg_chk("reset_state", 22'h000000, 1'b0, 3'b000);

    // Combinational instance; flags are {aeb,agb,alb}.
    comb_vec("add_1p0_0p5",   22'h100000, 22'h080000, 1'b1, 22'h180000, 1'b0, 3'b010);
    comb_vec("sub_0p5_1p0",   22'h080000, 22'h100000, 1'b0, 22'h380000, 1'b0, 3'b001);
    comb_vec("add_ovf_wrap",  22'h180000, 22'h100000, 1'b1, 22'h280000, 1'b1, 3'b010);
    comb_vec("sub_ovf_neg2",  22'h200000, 22'h000001, 1'b0, 22'h1FFFFF, 1'b1, 3'b001);
    comb_vec("cmp_negeps",    22'h3FFFFF, 22'h000001, 1'b1, 22'h000000, 1'b0, 3'b001);
    comb_vec("eq_sub_zero",   22'h0C90FD, 22'h0C90FD, 1'b0, 22'h000000, 1'b0, 3'b100);
    comb_vec("eq_add",        22'h0C90FD, 22'h0C90FD, 1'b1, 22'h1921FA, 1'b0, 3'b100);
    comb_vec("sub_mostneg",   22'h000000, 22'h200000, 1'b0, 22'h200000, 1'b1, 3'b010);
    comb_vec("add_maxpos",    22'h1FFFFF, 22'h1FFFFE, 1'b1, 22'h3FFFFD, 1'b1, 3'b010);
    comb_vec("add_negneg",    22'h200000, 22'h200001, 1'b1, 22'h000001, 1'b1, 3'b001);
    comb_vec("mostneg_lt",    22'h200000, 22'h3FFFFF, 1'b0, 22'h200001, 1'b0, 3'b001);

    // Registered instance must still be cleared: reset was held throughout.
    reg_chk("reset_held", 22'h000000, 1'b0, 3'b000);

    @(negedge clk);
    rst_n   = 1'b1;
    clk_en  = 1'b1;
    dataa   = 22'h100000;
    datab   = 22'h100000;
    add_sub = 1'b1;
    #1;
    reg_chk("pre_edge", 22'h000000, 1'b0, 3'b000);
    @(negedge clk);
    reg_chk("lat1_capture", 22'h200000, 1'b1, 3'b100);

    clk_en  = 1'b0;
    dataa   = 22'h080000;
    datab   = 22'h100000;
    add_sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reg_chk("hold_en0", 22'h200000, 1'b1, 3'b100);

    clk_en = 1'b1;
    @(negedge clk);
    reg_chk("resume_en1", 22'h380000, 1'b0, 3'b001);

    // Reset asserted between edges must clear immediately.
    #2;
    rst_n   = 1'b0;
    dataa   = 22'h180000;
    datab   = 22'h100000;
    add_sub = 1'b1;
    #1;
    reg_chk("async_reset", 22'h000000, 1'b0, 3'b000);
    @(negedge clk);
    reg_chk("reset_low_edge", 22'h000000, 1'b0, 3'b000);

    rst_n = 1'b1;
    @(negedge clk);
    reg_chk("post_reset_cap", 22'h280000, 1'b1, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_addsub_cmp_signed.md
Name:
fixed_point_addsub_cmp_signed

Overview:
- Signed two's-complement fixed-point arithmetic primitive for the CORDIC datapath.
- Combines two functions:
  - an add/subtract unit whose direction is selected by a control bit (the Fixed_Add_Sub_signed function);
  - a signed magnitude comparator (the Fixed_Point_gt_signed function) giving equal, greater-than and less-than flags.
- Used per CORDIC stage for x/y/angle update and angle-vs-target decision.
- Optional output register stage with clock enable.

Parameters:
- INTEGER_WIDTH, 2, integer bits including sign (Q format).
- DECIMAL_WIDTH, 20, fractional bits.
- DATA_WIDTH, INTEGER_WIDTH+DECIMAL_WIDTH (22), operand/result width.
- LATENCY, 0, 0 = combinational outputs, 1 = outputs registered once. Other values are illegal; elaboration error.

Ports:
- clk  input  1  clock; used only when LATENCY=1.
- rst_n  input  1  asynchronous active-low reset; used only when LATENCY=1.
- clk_en  input  1  register enable (LATENCY=1); ignored when LATENCY=0.
- dataa  input  DATA_WIDTH  signed operand A.
- datab  input  DATA_WIDTH  signed operand B.
- add_sub  input  1  1 = A+B, 0 = A-B.
- result  output  DATA_WIDTH  signed sum/difference, wrapped.
- overflow  output  1  signed overflow of the add/sub.
- aeb  output  1  A == B.
- agb  output  1  A > B (signed).
- alb  output  1  A < B (signed).

Behaviour:
- Operand format: both operands are two's complement Q(INTEGER_WIDTH).(DECIMAL_WIDTH); 1.0 = 2^DECIMAL_WIDTH (0x100000 at defaults).
- Comparison is always signed, including when the caller drives an unsigned-typed vector; bit DATA_WIDTH-1 is the sign.
- add_sub=1: result = (A + B) mod 2^DATA_WIDTH.
- add_sub=0: result = (A - B) mod 2^DATA_WIDTH. No saturation; wrap-around only.
- overflow:
  - add: set when A and B have the same sign and the result sign differs.
  - sub: set when A and B have different signs and the result sign differs from A.
- A - B with B = most-negative value: computed as A + ~B + 1; wraps per the rules above, overflow asserted when applicable.
- Comparator flags:
  - Exactly one of aeb/agb/alb is 1 for any inputs.
  - Flags do not depend on add_sub.
- Comparator boundaries: most-negative < all other values; max-positive > all other values; 0 vs -0 is not applicable (single zero).
- LATENCY=0:
  - All outputs are pure combinational functions of dataa/datab/add_sub.
  - clk, rst_n and clk_en have no effect.
- LATENCY=1:
  - All outputs are registered on posedge clk when clk_en=1; they hold their value when clk_en=0.
  - Latency is exactly 1 cycle from input sample to output.
- Reset (LATENCY=1):
  - rst_n low clears immediately, asynchronously: result=0, overflow=0, aeb=0, agb=0, alb=0.
  - Assertion mid-operation discards in-flight data.
  - The first capture after deassertion happens on the first posedge with rst_n high and clk_en=1.
- No internal state beyond the optional output register; no handshake.

Test Plan:
- Add: A=0x100000 (1.0), B=0x080000 (0.5), add_sub=1 -> result=0x180000, overflow=0, agb=1, aeb=0, alb=0.
- Subtract: A=0x080000, B=0x100000, add_sub=0 -> result=0x380000 (-0.5), overflow=0, alb=1.
- Overflow wrap: A=0x180000 (1.5), B=0x100000, add_sub=1 -> result=0x280000 (-1.5), overflow=1. Also A=0x200000 (-2.0), B=0x000001, add_sub=0 -> result=0x1FFFFF, overflow=1.
- Signed compare:
  - A=0x3FFFFF (-2^-20), B=0x000001 -> alb=1, agb=0, aeb=0.
  - A=B=0x0C90FD -> aeb=1, result with add_sub=0 is 0.
- LATENCY=1 timing:
  - Drive A=0x100000, B=0x100000, add_sub=1 with clk_en=1 -> result=0x200000 and overflow=1 appear one posedge later.
  - Drop clk_en and change inputs -> outputs hold.
- LATENCY=1 reset: pull rst_n low between clock edges -> all outputs 0 immediately. Release and clock once with clk_en=1 -> outputs reflect the current inputs.
